alu_op_sequencer: RTL and testbench
===================================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width of operands and result.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have ports in_valid (input, 1) and in_ready (output, 1): request handshake.
REQ-005 SHALL have port in_op, input, 2 bits: 00 ADD (A+B), 01 NOT (~A), 10 SUB (A-B), 11 NEG (-A).
REQ-006 SHALL have ports in_a and in_b, input, WIDTH bits: operands.
REQ-007 SHALL have ports alu_a and alu_b, output, WIDTH bits: operands driven to the shared NOT/ADD unit.
REQ-008 SHALL have port alu_select, output, 1 bit: 1 makes the unit return ~alu_a, 0 makes it return alu_a+alu_b.
REQ-009 SHALL have port alu_result, input, WIDTH bits: combinational result returned by the unit.
REQ-010 SHALL have ports out_valid (output, 1) and out_ready (input, 1): result handshake.
REQ-011 SHALL have port out_data, output, WIDTH bits: final result.
REQ-012 SHALL have port out_zero, output, 1 bit: high when out_data is all zeros.

Function
REQ-013 SHALL implement states IDLE, P1, P2, P3 and DONE.
REQ-014 SHALL drive in_ready high only in IDLE; in_valid SHALL be ignored in all other states.
REQ-015 SHALL, on a clk edge in IDLE with in_valid high, latch in_op, in_a and in_b, and enter P1.
REQ-016 SHALL drive alu_a, alu_b and alu_select combinationally from state and the latched values.
REQ-017 SHALL capture alu_result into an internal WIDTH-bit temporary at the end of each non-final pass.
REQ-018 SHALL use this pass schedule: ADD, one pass: P1 drives a=A, b=B, sel=0.
REQ-019 SHALL use this pass schedule: NOT, one pass: P1 drives a=A, b=0, sel=1.
REQ-020 SHALL use this pass schedule: SUB, three passes: P1 drives a=B, b=0, sel=1; P2 drives a=tmp, b=A, sel=0; P3 drives a=tmp, b=1, sel=0.
REQ-021 SHALL use this pass schedule: NEG, two passes: P1 drives a=A, b=0, sel=1; P2 drives a=tmp, b=1, sel=0.
REQ-022 SHALL, at the end of the final pass, load alu_result into out_data and enter DONE.
REQ-023 SHALL make out_valid visible 1 (ADD, NOT), 2 (NEG) or 3 (SUB) cycles after the accepting edge.
REQ-024 SHALL use modulo 2^WIDTH arithmetic with no carry or overflow output; 0-1 yields all ones.
REQ-025 SHALL drive alu_a=0, alu_b=0 and alu_select=0 in IDLE and DONE.
REQ-026 SHALL assert out_valid only in DONE.
REQ-027 SHALL hold out_data and out_zero stable while out_valid is high and out_ready is low.
REQ-028 SHALL return to IDLE on an edge in DONE with out_ready high; the next request can therefore be accepted no earlier than the following edge.
REQ-029 SHALL NOT change out_data when in IDLE; out_data retains the last result.

Reset
REQ-030 SHALL, on an edge with reset high, enter IDLE and clear out_data, the temporary and the latched operands and op to 0.
REQ-031 SHALL give out_valid=0, out_zero=1, in_ready=1, alu_a=0, alu_b=0 and alu_select=0 after reset.
REQ-032 SHALL abandon an in-progress operation or a pending result on reset with no output handshake.
REQ-033 SHALL give reset priority over in_valid and out_ready on the same edge.

Verification
REQ-034 ADD test: in_a=5, in_b=7 -> alu_select=0 in P1; out_data=12 and out_zero=0 one cycle after accept.
REQ-035 SUB test: in_a=10, in_b=3 -> alu_select sequence 1,0,0; out_data=7 three cycles after accept. Also in_a=0, in_b=1 -> 0xFFFFFFFF.
REQ-036 NOT/NEG test: NOT of 0 -> 0xFFFFFFFF; NEG of 1 -> 0xFFFFFFFF after 2 cycles; NEG of 0 -> 0 with out_zero=1.
REQ-037 Backpressure test: hold out_ready=0 for 5 cycles in DONE -> out_valid and out_data stable and in_ready=0; pulse out_ready -> IDLE and in_ready=1 next cycle.
REQ-038 Busy test: change in_valid and operands during SUB P2 -> request ignored and result unaffected.
REQ-039 Reset test: assert reset during SUB P2 -> next cycle in IDLE, out_valid=0, out_data=0, in_ready=1.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Multi-pass ALU sequencer: builds ADD/NOT/SUB/NEG from a shared NOT/ADD unit
// by scheduling one to three passes through it and holding the final result.
module alu_op_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_select,
  input  logic [WIDTH-1:0] alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_P1   = 3'd1,
    S_P2   = 3'd2,
    S_P3   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_NOT = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_NEG = 2'b11;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] tmp_q, tmp_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             final_pass;

  // The last pass of each schedule writes out_q; earlier passes write tmp_q.
  always_comb begin
    final_pass = 1'b0;
    unique case (state_q)
      S_P1:    final_pass = (op_q == OP_ADD) || (op_q == OP_NOT);
      S_P2:    final_pass = (op_q == OP_NEG);
      S_P3:    final_pass = 1'b1;
      default: final_pass = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      tmp_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tmp_q   <= tmp_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    tmp_d   = tmp_q;
    out_d   = out_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d    = in_op;
          a_d     = in_a;
          b_d     = in_b;
          state_d = S_P1;
        end
      end
      S_P1, S_P2, S_P3: begin
        if (final_pass) begin
          out_d   = alu_result;
          state_d = S_DONE;
        end else begin
          tmp_d   = alu_result;
          state_d = (state_q == S_P1) ? S_P2 : S_P3;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // SUB is A + ~B + 1; NEG is ~A + 1.
  always_comb begin
    alu_a      = '0;
    alu_b      = '0;
    alu_select = 1'b0;
    unique case (state_q)
      S_P1: begin
        unique case (op_q)
          OP_ADD: begin alu_a = a_q; alu_b = b_q; end
          OP_SUB: begin alu_a = b_q; alu_select = 1'b1; end
          default: begin alu_a = a_q; alu_select = 1'b1; end
        endcase
      end
      S_P2: begin
        alu_a = tmp_q;
        alu_b = (op_q == OP_SUB) ? a_q : WIDTH'(1);
      end
      S_P3: begin
        alu_a = tmp_q;
        alu_b = WIDTH'(1);
      end
      default: begin
        alu_a      = '0;
        alu_b      = '0;
        alu_select = 1'b0;
      end
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    out_data  = out_q;
    out_zero  = (out_q == '0);
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer; models the shared NOT/ADD unit and
// checks pass schedule, latency, backpressure, busy-ignore and reset.
module tb_alu_op_sequencer;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_a, in_b;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic             alu_select;
  logic [WIDTH-1:0] alu_result;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  // Shared NOT/ADD unit
  assign alu_result = alu_select ? ~alu_a : (alu_a + alu_b);

  alu_op_sequencer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_select (alu_select),
    .alu_result (alu_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_zero   (out_zero)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input int passes, input logic [2:0] sel_seq,
                        input logic [31:0] a1, input logic [31:0] exp,
                        input int hold, input bit busy);
    check({tag, " in_ready idle"}, {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    tick();
    in_valid = 1'b0;
    check({tag, " alu_a P1"}, alu_a, a1);
    for (int p = 0; p < passes; p++) begin
      check($sformatf("%s sel pass%0d", tag, p), {31'b0, alu_select}, {31'b0, sel_seq[p]});
      check($sformatf("%s busy pass%0d", tag, p), {30'b0, out_valid, in_ready}, 32'd0);
      if (busy && p == 1) begin
        in_valid = 1'b1; in_op = 2'b00; in_a = ~a; in_b = a ^ b ^ 32'h55;
      end
      tick();
      in_valid = 1'b0;
    end
    check({tag, " out_valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, " out_data"}, out_data, exp);
    check({tag, " out_zero"}, {31'b0, out_zero}, {31'b0, exp == 32'd0});
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; in_a = 32'hDEAD_BEEF;
      tick();
      check($sformatf("%s hold%0d", tag, h), {29'b0, out_valid, in_ready, out_zero},
            {29'b0, 1'b1, 1'b0, exp == 32'd0});
      check($sformatf("%s hold%0d data", tag, h), out_data, exp);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " back idle"}, {29'b0, in_ready, out_valid, alu_select}, 32'b100);
    check({tag, " retained"}, out_data, exp);
    check({tag, " alu_a idle"}, alu_a, 32'd0);
    $display("[TB] %s op=%0d a=%h b=%h -> %h", tag, op, a, b, exp);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (3) tick();
    check("rst in_ready", {31'b0, in_ready}, 32'd1);
    check("rst out_valid", {31'b0, out_valid}, 32'd0);
    check("rst out_zero", {31'b0, out_zero}, 32'd1);
    check("rst out_data", out_data, 32'd0);
    check("rst alu", {alu_a[15:0], alu_b[14:0], alu_select}, 32'd0);
    reset = 1'b0;
    tick();

    run_op("ADD",    2'b00, 32'd5,  32'd7, 1, 3'b000, 32'd5, 32'd12,        0, 1'b0);
    run_op("SUB",    2'b10, 32'd10, 32'd3, 3, 3'b001, 32'd3, 32'd7,         0, 1'b1);
    run_op("SUB0-1", 2'b10, 32'd0,  32'd1, 3, 3'b001, 32'd1, 32'hFFFF_FFFF, 0, 1'b0);
    run_op("NOT0",   2'b01, 32'd0,  32'd9, 1, 3'b001, 32'd0, 32'hFFFF_FFFF, 0, 1'b0);
    run_op("NEG1",   2'b11, 32'd1,  32'd0, 2, 3'b001, 32'd1, 32'hFFFF_FFFF, 0, 1'b0);
    run_op("NEG0",   2'b11, 32'd0,  32'd4, 2, 3'b001, 32'd0, 32'd0,         0, 1'b0);
    run_op("BP",     2'b00, 32'h1234, 32'h1111, 1, 3'b000, 32'h1234, 32'h2345, 5, 1'b0);
    run_op("WRAP",   2'b00, 32'hFFFF_FFFF, 32'd1, 1, 3'b000, 32'hFFFF_FFFF, 32'd0, 0, 1'b0);
    run_op("SUBBIG", 2'b10, 32'h8000_0000, 32'h0000_0001, 3, 3'b001, 32'd1, 32'h7FFF_FFFF, 0, 1'b0);

    // Reset mid-SUB (in P2) with in_valid high on the same edge
    in_valid = 1'b1; in_op = 2'b10; in_a = 32'd10; in_b = 32'd3;
    tick();
    in_valid = 1'b0;
    tick();
    check("rstP2 pre sel", {31'b0, alu_select}, 32'd0);
    check("rstP2 pre alu_b", alu_b, 32'd10);
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("rstP2 in_ready", {31'b0, in_ready}, 32'd1);
    check("rstP2 out_valid", {31'b0, out_valid}, 32'd0);
    check("rstP2 out_data", out_data, 32'd0);
    check("rstP2 alu_a", alu_a, 32'd0);
    $display("[TB] RESET during SUB P2 -> idle");
    tick();
    check("rstP2 stays idle", {31'b0, in_ready}, 32'd1);

    run_op("POSTRST", 2'b10, 32'd100, 32'd58, 3, 3'b001, 32'd58, 32'd42, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
